mem_port_arbiter: RTL and testbench

Shares the single-ported main memory between the instruction-fetch path and the load/store data path of the multicycle core. Each requester holds a level request until a one-cycle done pulse. Simultaneous requests are resolved round-robin. Each memory access is guarded by a watchdog timeout that aborts it with an error flag.

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// load/store data, with a per-access watchdog that aborts stalled accesses.
module mem_port_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_done,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state_r;
  logic       last_grant_r;  // 1'b1 = data port was granted last
  logic [7:0] cnt_r;
  logic       f_ok_s;
  logic       d_ok_s;
  logic       grant_f_s;
  logic       grant_d_s;
  logic       expire_s;

  // Arbitration: a port is masked while its done pulse is high.
  always_comb begin
    f_ok_s    = f_req & ~f_done;
    d_ok_s    = d_req & ~d_done;
    grant_f_s = 1'b0;
    grant_d_s = 1'b0;
    expire_s  = (cnt_r == LAST_WAIT);
    if (f_ok_s && d_ok_s) begin
      if (last_grant_r) begin
        grant_f_s = 1'b1;
      end else begin
        grant_d_s = 1'b1;
      end
    end else if (f_ok_s) begin
      grant_f_s = 1'b1;
    end else if (d_ok_s) begin
      grant_d_s = 1'b1;
    end else begin
      grant_f_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // Access sequencing, request capture and registered completion outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      cnt_r        <= 8'd0;
      f_done       <= 1'b0;
      d_done       <= 1'b0;
      err          <= 1'b0;
      f_rdata      <= {DW{1'b0}};
      d_rdata      <= {DW{1'b0}};
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= {AW{1'b0}};
      mem_wdata    <= {DW{1'b0}};
    end else begin
      f_done <= 1'b0;
      d_done <= 1'b0;
      err    <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= 8'd0;
          if (grant_f_s) begin
            state_r      <= FETCH;
            last_grant_r <= 1'b0;
            mem_en       <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= f_addr;
          end else if (grant_d_s) begin
            state_r      <= DATA;
            last_grant_r <= 1'b1;
            mem_en       <= 1'b1;
            mem_we       <= d_we;
            mem_addr     <= d_addr;
            mem_wdata    <= d_wdata;
          end else begin
            state_r <= IDLE;
          end
        end
        FETCH, DATA: begin
          if (mem_ready || expire_s) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            err     <= ~mem_ready;
            if (state_r == FETCH) begin
              f_done  <= 1'b1;
              f_rdata <= mem_ready ? mem_rdata : {DW{1'b0}};
            end else begin
              d_done  <= 1'b1;
              // Stores and aborted loads both return zero.
              d_rdata <= (mem_ready && !mem_we) ? mem_rdata : {DW{1'b0}};
            end
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus randomized
// traffic from both requesters against a behavioural memory model.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_done;
  logic [DW-1:0] f_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  exp_t          f_q[$];
  exp_t          d_q[$];
  logic [DW-1:0] mem[int];
  logic [DW-1:0] shadow[int];
  bit            zero_wait = 1'b0;
  int            force_target = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Unwritten locations read as a fixed function of the address.
  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : (a ^ 16'h5A5A);
  endfunction

  // Memory responder: addresses with bit 15 set never answer.
  initial begin
    int wcnt;
    int target;
    int en_cnt;
    bit in_acc;
    bit dead;
    mem_ready = 1'b0;
    mem_rdata = '0;
    in_acc = 1'b0;
    wcnt = 0; target = 0; en_cnt = 0; dead = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        in_acc = 1'b0;
        mem_ready = 1'b0;
      end else if (mem_en) begin
        if (!in_acc) begin
          in_acc = 1'b1;
          wcnt = 0;
          en_cnt = 0;
          dead = mem_addr[15];
          if (dead) target = 1000;
          else if (force_target >= 0) target = force_target;
          else if (zero_wait) target = 0;
          else begin
            case ($urandom_range(0, 3))
              0: target = 0;
              1: target = TIMEOUT - 1;
              default: target = $urandom_range(0, 5);
            endcase
          end
        end
        en_cnt++;
        if (wcnt == target) begin
          mem_ready = 1'b1;
          if (mem_we) begin
            mem[int'(mem_addr)] = mem_wdata;
            mem_rdata = DW'($urandom);
          end else begin
            mem_rdata = mem_rd(mem_addr);
          end
        end else begin
          mem_ready = 1'b0;
          mem_rdata = DW'($urandom);
        end
        wcnt++;
      end else begin
        if (in_acc) begin
          in_acc = 1'b0;
          if (dead) check("timeout_en_cycles", en_cnt, TIMEOUT);
          else check("access_en_cycles", en_cnt, target + 1);
        end
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = DW'($urandom);
      end
    end
  end

  // Monitor: pops the scoreboard whenever a done pulse appears.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (f_done || d_done) check("done_overlap", {31'd0, f_done & d_done}, 32'd0);
      if (err) check("err_without_done", {31'd0, f_done | d_done}, 32'd1);
      if (f_done) begin
        check("f_done_expected", {31'd0, f_q.size() > 0}, 32'd1);
        if (f_q.size() > 0) begin
          e = f_q.pop_front();
          check("f_rdata", {16'd0, f_rdata}, {16'd0, e.rdata});
          check("f_err", {31'd0, err}, {31'd0, e.err});
        end
      end
      if (d_done) begin
        check("d_done_expected", {31'd0, d_q.size() > 0}, 32'd1);
        if (d_q.size() > 0) begin
          e = d_q.pop_front();
          check("d_rdata", {16'd0, d_rdata}, {16'd0, e.rdata});
          check("d_err", {31'd0, err}, {31'd0, e.err});
        end
      end
    end
  end

  task automatic wait_done(input bit dport);
    int k;
    for (k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (dport ? d_done : f_done) break;
    end
    check(dport ? "d_done_in_time" : "f_done_in_time", {31'd0, k < 300}, 32'd1);
  endtask

  task automatic do_fetch(input logic [AW-1:0] a);
    exp_t e;
    e.err = a[15];
    e.rdata = a[15] ? 16'h0000 : (a ^ 16'h5A5A);
    f_q.push_back(e);
    f_addr = a;
    f_req = 1'b1;
    wait_done(1'b0);
    f_req = 1'b0;
    f_addr = AW'($urandom);
  endtask

  task automatic do_data(input logic [AW-1:0] a, input bit we, input logic [DW-1:0] wd);
    exp_t e;
    e.err = a[15];
    if (a[15] || we) e.rdata = 16'h0000;
    else e.rdata = shadow.exists(int'(a)) ? shadow[int'(a)] : (a ^ 16'h5A5A);
    if (!a[15] && we) shadow[int'(a)] = wd;
    d_q.push_back(e);
    d_addr = a;
    d_we = we;
    d_wdata = wd;
    d_req = 1'b1;
    wait_done(1'b1);
    d_req = 1'b0;
    d_addr = AW'($urandom);
    d_wdata = DW'($urandom);
  endtask

  task automatic wait_mem_en(input string name);
    int k;
    for (k = 0; k < 20; k++) begin
      if (mem_en) break;
      @(posedge clk); #1;
    end
    check(name, {31'd0, mem_en}, 32'd1);
  endtask

  initial begin
    exp_t e;
    int last;
    // Reset values
    #2;
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    check("rst_dones", {30'd0, f_done, d_done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", {f_rdata, d_rdata}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Contention: both held, zero-wait memory, fetch wins first tie
    zero_wait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e.err = 1'b0; e.rdata = 16'h0100 ^ 16'h5A5A; f_q.push_back(e);
      e.rdata = 16'h4100 ^ 16'h5A5A; d_q.push_back(e);
    end
    f_addr = 16'h0100; d_addr = 16'h4100; d_we = 1'b0;
    f_req = 1'b1; d_req = 1'b1;
    last = 0;
    for (int k = 0; k < 8; k++) begin
      int j;
      for (j = 0; j < 20; j++) begin
        @(posedge clk); #1;
        if (f_done || d_done) break;
      end
      check("contention_done_in_time", {31'd0, j < 20}, 32'd1);
      check("contention_port", {31'd0, d_done}, k % 2);
      if (k > 0) check("contention_gap", cyc - last, 2);
      last = cyc;
      if (k == 6) begin
        if (f_done) f_req = 1'b0; else d_req = 1'b0;
      end
      if (k == 7) begin
        f_req = 1'b0; d_req = 1'b0;
      end
    end
    repeat (2) @(posedge clk);
    #1;

    // Single fetch latency
    e.err = 1'b0; e.rdata = 16'h0040 ^ 16'h5A5A; f_q.push_back(e);
    f_addr = 16'h0040; f_req = 1'b1;
    @(posedge clk); #1;
    check("fetch_mem_en", {31'd0, mem_en}, 32'd1);
    check("fetch_mem_addr", {16'd0, mem_addr}, 32'h0040);
    check("fetch_mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    check("fetch_done_latency", {31'd0, f_done}, 32'd1);
    f_req = 1'b0;
    zero_wait = 1'b0;

    // Store with 3 waits, then read back
    force_target = 3;
    do_data(16'h4003, 1'b1, 16'hBEEF);
    force_target = -1;
    do_data(16'h4003, 1'b0, 16'h0000);

    // Timeout on a load, then a fetch proceeds
    do_data(16'h8004, 1'b0, 16'h0000);
    do_fetch(16'h0200);

    // Ready on the last allowed wait cycle counts as success
    force_target = TIMEOUT - 1;
    do_fetch(16'h0300);
    force_target = -1;

    // Asynchronous reset in the middle of a data access
    d_addr = 16'h8010; d_we = 1'b0; d_req = 1'b1;
    @(posedge clk); #1;
    wait_mem_en("rst_test_grant");
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_mem_en", {31'd0, mem_en}, 32'd0);
    check("midrst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("midrst_outputs", {27'd0, mem_we, f_done, d_done, err, 1'b0}, 32'd0);
    check("midrst_rdata", {f_rdata, d_rdata}, 32'd0);
    d_addr = 16'h4020;
    e.err = 1'b0; e.rdata = 16'h4020 ^ 16'h5A5A; d_q.push_back(e);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_mem_en("rst_regrant");
    check("rst_regrant_addr", {16'd0, mem_addr}, 32'h4020);
    wait_done(1'b1);
    d_req = 1'b0;

    // Randomized traffic from both ports
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          if ($urandom_range(0, 9) == 0) do_fetch(16'h8000 | AW'($urandom_range(0, 255)));
          else do_fetch(AW'($urandom_range(0, 16'h3FFF)));
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          if ($urandom_range(0, 7) == 0)
            do_data(16'h8000 | AW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), DW'($urandom));
          else
            do_data(16'h4000 + AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), DW'($urandom));
        end
      end
    join
    repeat (5) @(posedge clk);
    #1;
    check("f_queue_drained", f_q.size(), 0);
    check("d_queue_drained", d_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
